// File: rtl/bus_demux_1t2_if.sv
// Request/response bus bundle shared by the initiator side and each target port.
// The master drives the request and accepts responses; the slave does the reverse.
interface bus_demux_1t2_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rdata;

    modport master (
        output valid, addr, wdata, we, rsp_ready,
        input  ready, rsp_valid, rdata
    );

    modport slave (
        input  valid, addr, wdata, we, rsp_ready,
        output ready, rsp_valid, rdata
    );
endinterface

// File: rtl/bus_demux_1t2.sv
// 1-to-2 data-bus request router: one registered forward stage steers requests by
// address, and an order FIFO of target bits returns load data in issue order.
module bus_demux_1t2 #(
    parameter logic [31:0] SPLIT_ADDR = 32'h1100_0000,
    parameter int          DEPTH      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    bus_demux_1t2_if.slave   up,
    bus_demux_1t2_if.master  dn0,
    bus_demux_1t2_if.master  dn1
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic             vld_p1;
    logic             tgt_p1;
    logic             we_p1;
    logic [31:0]      addr_p1;
    logic [31:0]      wdata_p1;

    logic [DEPTH-1:0] ord_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic fifo_full;
    logic fifo_empty;
    logic head_tgt;
    logic sel_ready;
    logic rsp_pop;
    logic req_acc;
    logic push;
    logic drain;
    logic tgt_in;

    assign tgt_in     = (up.addr >= SPLIT_ADDR);
    assign fifo_full  = (count == CW'(DEPTH));
    assign fifo_empty = (count == '0);
    assign head_tgt   = ord_q[rd_ptr];
    assign sel_ready  = tgt_p1 ? dn1.ready : dn0.ready;
    assign drain      = vld_p1 & sel_ready;

    // A full FIFO still admits a load in the cycle a response leaves it.
    assign up.ready = rst_n & (!vld_p1 | sel_ready) & !(!up.we & fifo_full & !rsp_pop);
    assign req_acc  = up.valid & up.ready;
    assign push     = req_acc & !up.we;

    assign dn0.valid = vld_p1 & !tgt_p1;
    assign dn1.valid = vld_p1 & tgt_p1;
    assign dn0.addr  = addr_p1;
    assign dn1.addr  = addr_p1;
    assign dn0.wdata = wdata_p1;
    assign dn1.wdata = wdata_p1;
    assign dn0.we    = we_p1;
    assign dn1.we    = we_p1;

    // Only the port at the FIFO head may hand a response upstream; the other waits.
    assign up.rsp_valid  = !fifo_empty & (head_tgt ? dn1.rsp_valid : dn0.rsp_valid);
    assign up.rdata      = head_tgt ? dn1.rdata : dn0.rdata;
    assign dn0.rsp_ready = !fifo_empty & !head_tgt & up.rsp_ready;
    assign dn1.rsp_ready = !fifo_empty &  head_tgt & up.rsp_ready;
    assign rsp_pop       = up.rsp_valid & up.rsp_ready;

    // Stage p1: forward register (valid is reset, payload is not)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (req_acc) begin
            vld_p1 <= 1'b1;
        end else if (drain) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (req_acc) begin
            addr_p1  <= up.addr;
            wdata_p1 <= up.wdata;
            we_p1    <= up.we;
            tgt_p1   <= tgt_in;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ord_q[wr_ptr] <= tgt_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rsp_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, rsp_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_demux_1t2.sv
// Directed and randomized checks of the 1-to-2 request router with in-order responses.
module tb_bus_demux_1t2;
    localparam logic [31:0] SPLIT = 32'h1100_0000;
    localparam int          NREQ  = 10000;
    localparam int          LIMIT = 60000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } req_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bus_demux_1t2_if up_if ();
    bus_demux_1t2_if d0_if ();
    bus_demux_1t2_if d1_if ();

    bus_demux_1t2 #(.SPLIT_ADDR(SPLIT), .DEPTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .up   (up_if),
        .dn0  (d0_if),
        .dn1  (d1_if)
    );

    req_t        iss_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] tq0[$];
    logic [31:0] tq1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed event expected none", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction

    task automatic take_dn(input int n, input logic [31:0] a, input logic [31:0] wd, input logic w);
        req_t r;
        if (iss_q.size() == 0) begin
            fail("rt_extra");
        end else begin
            r = iss_q.pop_front();
            chk("rt_addr", a, r.addr);
            chk("rt_port", 32'(n), 32'(r.addr >= SPLIT));
            chk("rt_we", 32'(w), 32'(r.we));
            if (r.we) chk("rt_wdata", wd, r.wdata);
            else if (n == 0) tq0.push_back(rd_of(a));
            else tq1.push_back(rd_of(a));
        end
    endtask

    logic [31:0] bnd_addr[3];
    logic        bnd_tgt[3];
    req_t        cur;
    logic        pend;
    int          nreq;
    int          cyc;

    initial begin
        rst_n = 1'b0;
        up_if.valid = 0; up_if.addr = 0; up_if.wdata = 0; up_if.we = 0; up_if.rsp_ready = 1;
        d0_if.ready = 1; d0_if.rsp_valid = 1; d0_if.rdata = 32'h1111_1111;
        d1_if.ready = 1; d1_if.rsp_valid = 1; d1_if.rdata = 32'h2222_2222;
        #1;
        chk("rst_req_ready", 32'(up_if.ready), 0);
        chk("rst_d0_valid", 32'(d0_if.valid), 0);
        chk("rst_d1_valid", 32'(d1_if.valid), 0);
        chk("rst_rsp_valid", 32'(up_if.rsp_valid), 0);
        chk("rst_d0_rsp_ready", 32'(d0_if.rsp_ready), 0);
        tick(); tick();
        rst_n = 1'b1;
        d0_if.rsp_valid = 0; d1_if.rsp_valid = 0;

        // Two loads to alternating ports, responses returned out of order by the targets
        up_if.valid = 1; up_if.addr = 32'h0000_0100; up_if.we = 0;
        #1 chk("first_accept", 32'(up_if.ready), 1);
        tick();
        up_if.addr = SPLIT;
        #1;
        chk("t1_d0_valid", 32'(d0_if.valid), 1);
        chk("t1_d0_addr", d0_if.addr, 32'h0000_0100);
        chk("t1_d1_valid", 32'(d1_if.valid), 0);
        chk("t1_req_ready", 32'(up_if.ready), 1);
        tick();
        up_if.valid = 0;
        #1;
        chk("t1_d1_valid2", 32'(d1_if.valid), 1);
        chk("t1_d0_valid2", 32'(d0_if.valid), 0);
        chk("t1_d1_addr", d1_if.addr, SPLIT);
        chk("t1_count2", 32'(dut.count), 2);
        tick();
        chk("t1_drained", 32'(d1_if.valid), 0);
        d1_if.rsp_valid = 1; d1_if.rdata = 32'h0000_BBBB; up_if.rsp_ready = 1;
        #1;
        chk("t1_hold_rsp_valid", 32'(up_if.rsp_valid), 0);
        chk("t1_hold_d1_ready", 32'(d1_if.rsp_ready), 0);
        tick();
        d0_if.rsp_valid = 1; d0_if.rdata = 32'h0000_AAAA;
        #1;
        chk("t1_rsp0_valid", 32'(up_if.rsp_valid), 1);
        chk("t1_rsp0_data", up_if.rdata, 32'h0000_AAAA);
        chk("t1_rsp0_d0_ready", 32'(d0_if.rsp_ready), 1);
        chk("t1_rsp0_d1_ready", 32'(d1_if.rsp_ready), 0);
        tick();
        d0_if.rsp_valid = 0;
        #1;
        chk("t1_rsp1_valid", 32'(up_if.rsp_valid), 1);
        chk("t1_rsp1_data", up_if.rdata, 32'h0000_BBBB);
        chk("t1_rsp1_d1_ready", 32'(d1_if.rsp_ready), 1);
        tick();
        d1_if.rsp_valid = 0;
        chk("t1_count0", 32'(dut.count), 0);

        // Store stalled by port 1 while a second store waits upstream
        d1_if.ready = 0;
        up_if.valid = 1; up_if.addr = 32'h1100_0004; up_if.wdata = 32'hDEAD_BEEF; up_if.we = 1;
        tick();
        up_if.addr = 32'h0000_0000; up_if.wdata = 32'h0000_1234;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) d1_if.ready = 1;
            #1;
            chk("t2_d1_valid", 32'(d1_if.valid), 1);
            chk("t2_d1_addr", d1_if.addr, 32'h1100_0004);
            chk("t2_d1_wdata", d1_if.wdata, 32'hDEAD_BEEF);
            chk("t2_req_ready", 32'(up_if.ready), (i == 3) ? 1 : 0);
            chk("t2_count", 32'(dut.count), 0);
            tick();
        end
        up_if.valid = 0;
        chk("t2_d0_valid", 32'(d0_if.valid), 1);
        chk("t2_d0_addr", d0_if.addr, 32'h0000_0000);
        chk("t2_d0_we", 32'(d0_if.we), 1);
        tick();

        // Address boundary routing, back-to-back stores
        bnd_addr[0] = 32'h10FF_FFFF; bnd_tgt[0] = 0;
        bnd_addr[1] = 32'h1100_0000; bnd_tgt[1] = 1;
        bnd_addr[2] = 32'hFFFF_FFFC; bnd_tgt[2] = 1;
        for (int i = 0; i < 3; i++) begin
            up_if.valid = 1; up_if.addr = bnd_addr[i]; up_if.we = 1;
            tick();
            chk("bnd_d1_valid", 32'(d1_if.valid), 32'(bnd_tgt[i]));
            chk("bnd_d0_valid", 32'(d0_if.valid), 32'(!bnd_tgt[i]));
        end
        up_if.valid = 0;
        tick();

        // Fill the order FIFO with four loads
        for (int i = 0; i < 4; i++) begin
            up_if.valid = 1; up_if.addr = 32'h0000_0200 + 32'(4 * i); up_if.we = 0;
            tick();
        end
        d0_if.ready = 0; up_if.addr = 32'h0000_0300;
        #1;
        chk("full_load_blocked", 32'(up_if.ready), 0);
        chk("full_count4", 32'(dut.count), 4);
        up_if.we = 1;
        #1 chk("full_store_blocked", 32'(up_if.ready), 0);
        up_if.valid = 0; d0_if.ready = 1;
        tick();
        chk("full_drained", 32'(d0_if.valid), 0);
        up_if.valid = 1; up_if.we = 0;
        #1 chk("full_load_nopop", 32'(up_if.ready), 0);
        d0_if.rsp_valid = 1; d0_if.rdata = 32'h5555_0000;
        #1;
        chk("full_load_on_pop", 32'(up_if.ready), 1);
        chk("full_pop_valid", 32'(up_if.rsp_valid), 1);
        chk("full_pop_data", up_if.rdata, 32'h5555_0000);
        tick();
        up_if.valid = 0; d0_if.rsp_valid = 0; d0_if.ready = 0;
        #1;
        chk("full_count_kept", 32'(dut.count), 4);
        chk("full_5th_staged", d0_if.addr, 32'h0000_0300);

        // Asynchronous reset with loads outstanding and the stage occupied
        d0_if.rsp_valid = 1;
        tick(); tick();
        chk("rs_count2", 32'(dut.count), 2);
        chk("rs_stage", 32'(d0_if.valid), 1);
        #2 rst_n = 0;
        #1;
        chk("rs_d0_valid", 32'(d0_if.valid), 0);
        chk("rs_d1_valid", 32'(d1_if.valid), 0);
        chk("rs_req_ready", 32'(up_if.ready), 0);
        chk("rs_rsp_valid", 32'(up_if.rsp_valid), 0);
        chk("rs_d0_rsp_ready", 32'(d0_if.rsp_ready), 0);
        chk("rs_count", 32'(dut.count), 0);
        tick(); tick();
        rst_n = 1;
        d1_if.rsp_valid = 1; d0_if.ready = 1;
        #1;
        chk("rs_rel_req_ready", 32'(up_if.ready), 1);
        chk("rs_rel_rsp_valid", 32'(up_if.rsp_valid), 0);
        chk("rs_rel_d0_rsp_ready", 32'(d0_if.rsp_ready), 0);
        chk("rs_rel_d1_rsp_ready", 32'(d1_if.rsp_ready), 0);
        tick();
        chk("rs_rel_count", 32'(dut.count), 0);
        chk("rs_rel_stage", 32'(d0_if.valid), 0);
        d0_if.rsp_valid = 0; d1_if.rsp_valid = 0;
        tick();

        // Random traffic with backpressure on every handshake
        pend = 0; nreq = 0; cyc = 0; cur = '0;
        while ((nreq < NREQ || iss_q.size() != 0 || exp_q.size() != 0) && cyc < LIMIT) begin
            if (!pend && nreq < NREQ) begin
                case ($urandom_range(0, 3))
                    0: cur.addr = $urandom_range(0, 32'h10FF_FFFF);
                    1: cur.addr = $urandom_range(32'h1100_0000, 32'hFFFF_FFFF);
                    2: cur.addr = 32'h10FF_FFFC + 32'($urandom_range(0, 7));
                    default: cur.addr = $urandom;
                endcase
                cur.wdata = $urandom;
                cur.we    = $urandom_range(0, 2) == 0;
                pend = 1;
            end
            up_if.valid     = pend && ($urandom_range(0, 7) != 0);
            up_if.addr      = cur.addr;
            up_if.wdata     = cur.wdata;
            up_if.we        = cur.we;
            up_if.rsp_ready = $urandom_range(0, 7) != 0;
            d0_if.ready     = $urandom_range(0, 7) != 0;
            d1_if.ready     = $urandom_range(0, 7) != 0;
            d0_if.rsp_valid = (tq0.size() != 0) && ($urandom_range(0, 3) != 0);
            d0_if.rdata     = (tq0.size() != 0) ? tq0[0] : 32'h0;
            d1_if.rsp_valid = (tq1.size() != 0) && ($urandom_range(0, 3) != 0);
            d1_if.rdata     = (tq1.size() != 0) ? tq1[0] : 32'h0;
            #1;
            if (d0_if.valid && d0_if.ready) take_dn(0, d0_if.addr, d0_if.wdata, d0_if.we);
            if (d1_if.valid && d1_if.ready) take_dn(1, d1_if.addr, d1_if.wdata, d1_if.we);
            if (d0_if.rsp_valid && d0_if.rsp_ready) void'(tq0.pop_front());
            if (d1_if.rsp_valid && d1_if.rsp_ready) void'(tq1.pop_front());
            if (up_if.rsp_valid && up_if.rsp_ready) begin
                if (exp_q.size() == 0) fail("rnd_rsp_extra");
                else chk("rnd_rsp_data", up_if.rdata, exp_q.pop_front());
            end
            if (up_if.valid && up_if.ready) begin
                iss_q.push_back(cur);
                if (!cur.we) exp_q.push_back(rd_of(cur.addr));
                pend = 0;
                nreq++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= LIMIT) fail("rnd_timeout");
        up_if.valid = 0; d0_if.rsp_valid = 0; d1_if.rsp_valid = 0;
        chk("rnd_nreq", 32'(nreq), 32'(NREQ));
        chk("rnd_end_count", 32'(dut.count), 0);
        chk("rnd_iss_left", 32'(iss_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
